// File: rtl/pst_pkg.sv
// Shared types and helpers for the PST core (phase width, phase mapping, encoder states).
package pst_pkg;

  localparam int unsigned PHASE_W = 8;
  localparam logic [PHASE_W-1:0] PHASE_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // Stronger intensity maps to an earlier phase.
  function automatic logic [PHASE_W-1:0] intensity_to_phase(input logic [PHASE_W-1:0] x);
    return PHASE_MAX - x;
  endfunction

endpackage

// File: rtl/phase_encoder_channel.sv
// One latency-coding channel: holds the active intensity, fires once per gamma cycle.
module phase_encoder_channel
  import pst_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               match_en,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               spike
);

  logic [PHASE_W-1:0] active_q;
  logic [PHASE_W-1:0] cur_val_c;
  logic               fired_q;
  logic               hit_c;

  // On a commit edge the incoming value is compared and the old fired bit is ignored.
  always_comb begin
    cur_val_c = commit ? load_val : active_q;
    hit_c     = match_en
              && (cur_val_c != '0)
              && (phase_in == intensity_to_phase(cur_val_c))
              && (commit || !fired_q);
  end

  // Active value, fired mask and one-clock spike pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      fired_q  <= 1'b0;
      spike    <= 1'b0;
    end else begin
      if (commit) begin
        active_q <= load_val;
        fired_q  <= hit_c;
      end else begin
        fired_q  <= fired_q | hit_c;
      end
      spike <= hit_c;
    end
  end

endmodule

// File: rtl/phase_encoder.sv
// Latency-coding front end: double-buffered intensity vector to one spike per channel per cycle.
module phase_encoder
  import pst_pkg::*;
#(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       phase_in,
  input  logic                     cycle_start_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          spike_out,
  output logic                     cycle_active,
  output logic                     underrun
);

  enc_state_e                state_q;
  enc_state_e                state_d;
  logic                      full_q;
  logic [N_CH*DATA_W-1:0]    shadow_q;
  logic                      accept_c;
  logic                      commit_c;
  logic                      match_en_c;
  logic                      underrun_d;
  logic                      cycle_active_d;

  // Shadow slot is open whenever it is empty.
  assign in_ready = !full_q;

  // Next state, commit/match enables and next registered status.
  always_comb begin
    state_d        = state_q;
    commit_c       = 1'b0;
    match_en_c     = 1'b0;
    underrun_d     = 1'b0;
    cycle_active_d = cycle_active;
    accept_c       = in_valid && !full_q;
    case (state_q)
      ST_IDLE: begin
        if (cycle_start_in) begin
          state_d        = ST_RUN;
          commit_c       = 1'b1;
          match_en_c     = 1'b1;
          cycle_active_d = full_q;
        end
      end
      ST_RUN: begin
        match_en_c = 1'b1;
        if (cycle_start_in) begin
          commit_c       = 1'b1;
          cycle_active_d = full_q;
          underrun_d     = !full_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Shadow buffer, handshake and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= 1'b0;
      shadow_q     <= '0;
      cycle_active <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (accept_c) begin
        full_q   <= 1'b1;
        shadow_q <= in_data;
      end else if (commit_c) begin
        full_q   <= 1'b0;
      end
      cycle_active <= cycle_active_d;
      underrun     <= underrun_d;
    end
  end

  // Per-channel encoders; an empty shadow commits silence.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [PHASE_W-1:0] load_val_c;
    assign load_val_c = full_q ? PHASE_W'(shadow_q[k*DATA_W +: DATA_W]) : '0;

    phase_encoder_channel u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .commit   (commit_c),
      .load_val (load_val_c),
      .match_en (match_en_c),
      .phase_in (phase_in),
      .spike    (spike_out[k])
    );
  end

endmodule

// File: tb/tb_phase_encoder.sv
// Randomized bench for phase_encoder against a per-gamma-cycle target list model.
module tb_phase_encoder;
  localparam int unsigned N_CH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           phase_in;
  logic                 cycle_start_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_CH*8-1:0]    in_data;
  logic [N_CH-1:0]      spike_out;
  logic                 cycle_active;
  logic                 underrun;

  phase_encoder #(.N_CH(N_CH), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .phase_in       (phase_in),
    .cycle_start_in (cycle_start_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .spike_out      (spike_out),
    .cycle_active   (cycle_active),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: running flag, one-entry shadow, outstanding target phase per channel (-1 = none).
  bit                m_run;
  bit                m_full;
  int                m_sh [N_CH];
  int                pend [N_CH];
  bit                exp_act;
  int                spikes_seen [N_CH];

  // Feeder: a held vector offered on in_valid until accepted.
  bit                feed_on;
  bit                have_vec;
  logic [N_CH*8-1:0] vec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N_CH*8-1:0] rand_vec();
    logic [N_CH*8-1:0] v;
    for (int k = 0; k < N_CH; k++)
      v[k*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    return v;
  endfunction

  function automatic logic [N_CH*8-1:0] fill_vec(input int a, input int b, input int c, input int d);
    logic [N_CH*8-1:0] v;
    int pat [4];
    pat = '{a, b, c, d};
    for (int k = 0; k < N_CH; k++) v[k*8 +: 8] = 8'(pat[k % 4]);
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_full = 0; exp_act = 0; have_vec = 0;
    for (int k = 0; k < N_CH; k++) begin m_sh[k] = 0; pend[k] = -1; end
  endtask

  // One clock: drive at posedge+1, check in_ready, predict, check outputs at next posedge+1.
  task automatic step(input int ph, input bit cs);
    bit [N_CH-1:0] exp_spk;
    bit            exp_und;
    bit            acc;
    phase_in       = 8'(ph);
    cycle_start_in = cs;
    if (!have_vec && feed_on && $urandom_range(0, 99) < 3) begin
      have_vec = 1;
      vec      = rand_vec();
    end
    in_valid = have_vec;
    in_data  = vec;
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_full));
    acc     = have_vec && !m_full;
    exp_spk = '0;
    exp_und = 0;
    if (cs) begin
      exp_und = m_run && !m_full;
      exp_act = m_full;
      for (int k = 0; k < N_CH; k++)
        pend[k] = (m_full && m_sh[k] != 0) ? 255 - m_sh[k] : -1;
      m_full = 0;
      m_run  = 1;
    end
    if (m_run)
      for (int k = 0; k < N_CH; k++)
        if (pend[k] == ph) begin exp_spk[k] = 1; pend[k] = -1; end
    if (acc) begin
      for (int k = 0; k < N_CH; k++) m_sh[k] = int'(vec[k*8 +: 8]);
      m_full   = 1;
      have_vec = 0;
    end
    @(posedge clk);
    #1;
    check("spike_out", 64'(spike_out), 64'(exp_spk));
    check("cycle_active", 64'(cycle_active), 64'(exp_act));
    check("underrun", 64'(underrun), 64'(exp_und));
    for (int k = 0; k < N_CH; k++) if (spike_out[k]) spikes_seen[k]++;
  endtask

  // A gamma cycle: strobe on the first clock, phase counts up and may wrap.
  task automatic run_cycle(input int start_ph, input int len);
    for (int i = 0; i < len; i++) step((start_ph + i) % 256, i == 0);
  endtask

  task automatic clear_seen();
    for (int k = 0; k < N_CH; k++) spikes_seen[k] = 0;
  endtask

  task automatic load_now(input logic [N_CH*8-1:0] v);
    have_vec = 1;
    vec      = v;
    step(7, 0);
  endtask

  task automatic mid_reset();
    #3 rst_n = 0;
    #1;
    check("rst_spike", 64'(spike_out), 64'(0));
    check("rst_active", 64'(cycle_active), 64'(0));
    check("rst_underrun", 64'(underrun), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    model_reset();
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; phase_in = '0; cycle_start_in = 0; in_valid = 0; in_data = '0;
    vec = '0; feed_on = 0;
    model_reset();
    clear_seen();
    #12;
    check("reset_spike", 64'(spike_out), 64'(0));
    check("reset_active", 64'(cycle_active), 64'(0));
    check("reset_underrun", 64'(underrun), 64'(0));
    check("reset_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Idle phase sweep without strobe: nothing happens.
    for (int i = 0; i < 300; i++) step(i % 256, 0);

    // Pattern {255,128,1,0}: one spike each for x!=0, none for x=0.
    load_now(fill_vec(255, 128, 1, 0));
    clear_seen();
    run_cycle(0, 256);
    for (int k = 0; k < N_CH; k++)
      check("pattern_count", 64'(spikes_seen[k]), 64'((k % 4 == 3) ? 0 : 1));

    // A loaded, B held while A waits; A in cycle n, B in cycle n+1, then underrun cycle.
    load_now(rand_vec());
    have_vec = 1;
    vec      = rand_vec();
    step(0, 0);
    check("b_stalled", 64'(in_ready), 64'(0));
    run_cycle(0, 256);
    run_cycle(0, 256);
    clear_seen();
    run_cycle(0, 256);
    for (int k = 0; k < N_CH; k++) check("underrun_silent", 64'(spikes_seen[k]), 64'(0));

    // Revisit target 130 inside one cycle: still one spike.
    load_now(fill_vec(125, 125, 200, 3));
    clear_seen();
    for (int p = 0; p < 136; p++) step(p, p == 0);
    for (int p = 125; p < 141; p++) step(p, 0);
    check("revisit_count", 64'(spikes_seen[0]), 64'(1));

    // Reset at phase 100 with target 205 pending: no spike, back to idle.
    load_now(fill_vec(50, 50, 50, 50));
    clear_seen();
    for (int p = 0; p <= 100; p++) step(p, p == 0);
    mid_reset();
    for (int p = 101; p < 256; p++) step(p, 0);
    check("reset_no_spike", 64'(spikes_seen[0]), 64'(0));

    // Randomized traffic with off-zero strobes and unstrobed wraps.
    feed_on = 1;
    for (int c = 0; c < 14; c++) run_cycle($urandom_range(0, 255), $urandom_range(180, 320));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
